// File: rtl/fmap_bconv_pool_unit_pkg.sv
// Shared defaults and layout helpers for the binary conv + max-pool stage.
// Patch and weight bits are packed row-major, with the channel index innermost.
package fmap_bconv_pool_unit_pkg;

    localparam int unsigned DEF_H        = 8;
    localparam int unsigned DEF_W        = 8;
    localparam int unsigned DEF_D        = 2;
    localparam int unsigned DEF_K        = 4;
    localparam int unsigned DEF_FH       = 3;
    localparam int unsigned DEF_FW       = 3;
    localparam int unsigned DEF_POOL_H   = 2;
    localparam int unsigned DEF_POOL_W   = 2;
    localparam int unsigned DEF_PAD      = 1;
    localparam int unsigned DEF_STRIDE_H = 1;
    localparam int unsigned DEF_STRIDE_W = 1;

    function automatic int unsigned cnt_width(input int unsigned nw);
        return $clog2(nw + 1);
    endfunction

    function automatic int unsigned num_windows(
        input int unsigned h, input int unsigned w, input int unsigned pad,
        input int unsigned fh, input int unsigned fw,
        input int unsigned sh, input int unsigned sw,
        input int unsigned ph, input int unsigned pw
    );
        return (((h + 2 * pad - fh) / sh + 1) / ph) * (((w + 2 * pad - fw) / sw + 1) / pw);
    endfunction

    // Bit index of (row, col, channel) in a row-major array row_w pixels wide.
    function automatic int unsigned pix_bit(
        input int unsigned r, input int unsigned c, input int unsigned d,
        input int unsigned row_w, input int unsigned depth
    );
        return (r * row_w + c) * depth + d;
    endfunction

    localparam int unsigned DEF_NW      = DEF_FH * DEF_FW * DEF_D;
    localparam int unsigned DEF_CNT_W   = cnt_width(DEF_NW);
    localparam int unsigned DEF_NUM_WIN = num_windows(DEF_H, DEF_W, DEF_PAD, DEF_FH, DEF_FW,
                                                      DEF_STRIDE_H, DEF_STRIDE_W,
                                                      DEF_POOL_H, DEF_POOL_W);

endpackage

// File: rtl/fmap_bconv_pool_unit_bpopcount.sv
// Combinational population count of an N-bit vector.
module fmap_bconv_pool_unit_bpopcount #(
    parameter int unsigned N     = 18,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     bits,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/fmap_bconv_pool_unit.sv
// Binary convolution + OR max-pool over one pooling-window patch per cycle.
// Three stages: XNOR vectors, popcounts, threshold/OR into the K-bit output pixel.
module fmap_bconv_pool_unit
    import fmap_bconv_pool_unit_pkg::*;
#(
    parameter int unsigned H        = DEF_H,
    parameter int unsigned W        = DEF_W,
    parameter int unsigned D        = DEF_D,
    parameter int unsigned K        = DEF_K,
    parameter int unsigned FH       = DEF_FH,
    parameter int unsigned FW       = DEF_FW,
    parameter int unsigned POOL_H   = DEF_POOL_H,
    parameter int unsigned POOL_W   = DEF_POOL_W,
    parameter int unsigned PAD      = DEF_PAD,
    parameter int unsigned STRIDE_H = DEF_STRIDE_H,
    parameter int unsigned STRIDE_W = DEF_STRIDE_W,
    localparam int unsigned IN_WINDOW_H = (POOL_H - 1) * STRIDE_H + FH,
    localparam int unsigned IN_WINDOW_W = (POOL_W - 1) * STRIDE_W + FW,
    localparam int unsigned IN_BITS     = IN_WINDOW_H * IN_WINDOW_W * D,
    localparam int unsigned NW          = FH * FW * D,
    localparam int unsigned CNT_W       = cnt_width(NW),
    localparam int unsigned AW          = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_en,
    input  logic [IN_BITS-1:0] data_in,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [NW-1:0]      cfg_weight,
    input  logic [CNT_W-1:0]   cfg_thr,
    output logic               out_en,
    output logic [K-1:0]       data_out,
    output logic               frame_done
);

    localparam int unsigned NP      = POOL_H * POOL_W;
    localparam int unsigned NUM_WIN = num_windows(H, W, PAD, FH, FW, STRIDE_H, STRIDE_W,
                                                  POOL_H, POOL_W);
    localparam int unsigned WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

    logic [NW-1:0]    weight_q [K];
    logic [CNT_W-1:0] thr_q    [K];
    logic [CNT_W-1:0] thr_s1_q [K];
    logic [CNT_W-1:0] thr_s2_q [K];

    logic [NW-1:0]    sub_win  [NP];
    logic [NW-1:0]    xnor_d   [K][NP];
    logic [NW-1:0]    xnor_q   [K][NP];
    logic [CNT_W-1:0] cnt_d    [K][NP];
    logic [CNT_W-1:0] cnt_q    [K][NP];
    logic [K-1:0]     pooled;

    logic             v1_q, v2_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic             win_last;
    logic             cfg_hit;

    assign cfg_hit  = cfg_we && (32'(cfg_addr) < K);
    assign win_last = (win_cnt_q == WIN_W'(NUM_WIN - 1));

    // Gather each conv position's FHxFW sub-window into filter bit order.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            sub_win[p] = '0;
        end
        for (int pr = 0; pr < POOL_H; pr++) begin
            for (int pc = 0; pc < POOL_W; pc++) begin
                for (int r = 0; r < FH; r++) begin
                    for (int c = 0; c < FW; c++) begin
                        for (int d = 0; d < D; d++) begin
                            sub_win[pr * POOL_W + pc][pix_bit(r, c, d, FW, D)] =
                                data_in[pix_bit(pr * STRIDE_H + r, pc * STRIDE_W + c, d,
                                                IN_WINDOW_W, D)];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < K; k++) begin
            for (int p = 0; p < NP; p++) begin
                xnor_d[k][p] = ~(sub_win[p] ^ weight_q[k]);
            end
        end
    end

    for (genvar k = 0; k < K; k++) begin : g_filt
        for (genvar p = 0; p < NP; p++) begin : g_pos
            fmap_bconv_pool_unit_bpopcount #(
                .N     (NW),
                .CNT_W (CNT_W)
            ) u_pop (
                .bits  (xnor_q[k][p]),
                .count (cnt_d[k][p])
            );
        end
    end

    always_comb begin
        pooled = '0;
        for (int k = 0; k < K; k++) begin
            for (int p = 0; p < NP; p++) begin
                pooled[k] = pooled[k] | (cnt_q[k][p] >= thr_s2_q[k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                weight_q[k] <= '0;
                thr_q[k]    <= '0;
            end
        end else if (cfg_hit) begin
            weight_q[cfg_addr] <= cfg_weight;
            thr_q[cfg_addr]    <= cfg_thr;
        end
    end

    // Thresholds travel with the patch so a same-edge config write cannot
    // change the compare of a patch already captured in S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int k = 0; k < K; k++) begin
                thr_s1_q[k] <= '0;
                thr_s2_q[k] <= '0;
                for (int p = 0; p < NP; p++) begin
                    xnor_q[k][p] <= '0;
                    cnt_q[k][p]  <= '0;
                end
            end
        end else begin
            v1_q <= in_en;
            v2_q <= v1_q;
            if (in_en) begin
                xnor_q   <= xnor_d;
                thr_s1_q <= thr_q;
            end
            if (v1_q) begin
                cnt_q    <= cnt_d;
                thr_s2_q <= thr_s1_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en     <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
            win_cnt_q  <= '0;
        end else begin
            out_en     <= v2_q;
            frame_done <= v2_q && win_last;
            if (v2_q) begin
                data_out  <= pooled;
                win_cnt_q <= win_last ? '0 : win_cnt_q + WIN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fmap_bconv_pool_unit.sv
// Scoreboard bench: stimulus pushes expected pixels, a negedge monitor pops and checks them.
module tb_fmap_bconv_pool_unit;

    localparam int IN_BITS = 32;
    localparam int NW      = 18;
    localparam int CNT_W   = 5;
    localparam int K       = 4;
    localparam int NUM_WIN = 16;

    localparam logic [IN_BITS-1:0] ONES   = 32'hFFFF_FFFF;
    localparam logic [IN_BITS-1:0] BLOCK  = 32'hFCFC_FC00;
    localparam logic [IN_BITS-1:0] BLOCK1 = 32'hFCEC_FC00;
    localparam logic [NW-1:0]      W_ONES = 18'h3FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_en = 1'b0;
    logic [IN_BITS-1:0] data_in = '0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_addr = '0;
    logic [NW-1:0]      cfg_weight = '0;
    logic [CNT_W-1:0]   cfg_thr = '0;
    logic               out_en;
    logic [K-1:0]       data_out;
    logic               frame_done;

    fmap_bconv_pool_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_en      (in_en),
        .data_in    (data_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_weight (cfg_weight),
        .cfg_thr    (cfg_thr),
        .out_en     (out_en),
        .data_out   (data_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [K-1:0] data;
        logic         fd;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_exp  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_en) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stale_out: got out_en=1 data_out=%b expected no output (cycle %0d)",
                             data_out, cyc);
                end else begin
                    e = sb.pop_front();
                    check("data_out", int'(data_out), int'(e.data));
                    check("frame_done", int'(frame_done), int'(e.fd));
                    check("latency_cycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_out: got out_en=0 expected output due at cycle %0d (cycle %0d)",
                         sb[0].due, cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [K-1:0] d);
        exp_t e;
        e.data = d;
        e.fd   = ((n_exp % NUM_WIN) == NUM_WIN - 1);
        e.due  = cyc + 3;
        sb.push_back(e);
        n_exp++;
    endtask

    task automatic send(input logic [IN_BITS-1:0] p, input logic [K-1:0] d);
        in_en   = 1'b1;
        data_in = p;
        push_exp(d);
        @(posedge clk);
        #1;
        in_en   = 1'b0;
        data_in = '0;
    endtask

    task automatic cfg(input int a, input logic [NW-1:0] w, input logic [CNT_W-1:0] t);
        cfg_we     = 1'b1;
        cfg_addr   = 2'(a);
        cfg_weight = w;
        cfg_thr    = t;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_std();
        cfg(0, W_ONES, 5'd18);
        cfg(1, '0, 5'd1);
        cfg(2, W_ONES, 5'd0);
        cfg(3, W_ONES, 5'd19);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        sb.delete();
        n_exp = 0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        // Reset held with in_en toggling: nothing may come out.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_en   = (i % 2 == 0);
            data_in = ONES;
            #3;
            check("rst_out_en", int'(out_en), 0);
        end
        in_en = 1'b0;
        @(negedge clk);
        check("rst_data_out", int'(data_out), 0);
        check("rst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Weights and thresholds reset to 0, so every activation fires.
        send(ONES, 4'b1111);
        drain();

        cfg_std();
        send(ONES, 4'b0101);
        send(BLOCK, 4'b0111);
        send(BLOCK1, 4'b0110);
        drain();

        // Framing: 20 back-to-back windows from a clean reset.
        apply_reset(3);
        cfg_std();
        for (int i = 0; i < 20; i++) begin
            send(ONES, 4'b0101);
        end
        drain();

        // Config write on the same edge as a patch: that patch sees the old filter.
        cfg_we     = 1'b1;
        cfg_addr   = 2'd0;
        cfg_weight = '0;
        cfg_thr    = 5'd18;
        in_en      = 1'b1;
        data_in    = ONES;
        push_exp(4'b0101);
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        in_en   = 1'b0;
        send(ONES, 4'b0100);
        drain();

        // Reset with patches in flight.
        for (int i = 0; i < 4; i++) begin
            send(ONES, 4'b0100);
        end
        #1;
        check("pre_rst_out_en", int'(out_en), 1);
        rst = 1'b1;
        sb.delete();
        n_exp = 0;
        #1;
        check("async_rst_out_en", int'(out_en), 0);
        check("async_rst_data_out", int'(data_out), 0);
        check("async_rst_frame_done", int'(frame_done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            send(ONES, 4'b1111);
        end
        drain();
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fmap_bconv_pool_unit.md
Name: fmap_bconv_pool_unit

Overview:
- Binary convolution + max-pool stage directly downstream of the input feature-map shift register.
- Consumes one pooling-window patch per valid cycle: an IN_WINDOW_H x IN_WINDOW_W x D bit patch.
- For each of K filters: XNOR-popcount over every conv position in the window, then threshold (folded batch-norm + sign), then OR-pool.
- Emits a K-bit binary output pixel; a 3-stage pipeline with window counting for frame-end signalling.

Parameters:
- H, 8, input fmap height
- W, 8, input fmap width
- D, 2, input channels (bits per pixel)
- K, 4, number of filters / output channels
- FH, 3, filter height
- FW, 3, filter width
- POOL_H, 2, pool height
- POOL_W, 2, pool width
- PAD, 1, zero padding per side
- STRIDE_H, 1, conv vertical stride
- STRIDE_W, 1, conv horizontal stride
- localparam IN_WINDOW_H, (POOL_H-1)*STRIDE_H+FH, patch height
- localparam IN_WINDOW_W, (POOL_W-1)*STRIDE_W+FW, patch width
- localparam NW, FH*FW*D, filter bits
- localparam CNT_W, $clog2(NW+1), popcount width
- localparam NUM_WIN, (((H+2*PAD-FH)/STRIDE_H+1)/POOL_H)*(((W+2*PAD-FW)/STRIDE_W+1)/POOL_W), windows per frame (16 at defaults)

Ports:
- clk, in, 1, clock, rising edge
- rst, in, 1, reset, asynchronous, active-high
- in_en, in, 1, patch valid
- data_in, in, IN_WINDOW_H*IN_WINDOW_W*D, patch; bit ((r*IN_WINDOW_W+c)*D+d)
- cfg_we, in, 1, filter/threshold write strobe
- cfg_addr, in, $clog2(K) (min 1), filter index
- cfg_weight, in, NW, filter bits; bit ((r*FW+c)*D+d)
- cfg_thr, in, CNT_W, match threshold
- out_en, out, 1, output valid
- data_out, out, K, pooled binary pixel; bit k = filter k
- frame_done, out, 1, high with the out_en of the last window of a frame

Behaviour:
- Encoding: bit 1 = +1, bit 0 = -1.
- matches(k,p) = popcount(XNOR(patch sub-window p, weight[k])).
- Sub-window p=(pr,pc) starts at row pr*STRIDE_H, column pc*STRIDE_W, with pr<POOL_H and pc<POOL_W.
- act(k,p) = (matches >= thr[k]), unsigned compare on CNT_W bits.
- data_out[k] = OR over all p of act(k,p).
- Pipeline, no backpressure; a new patch is accepted every cycle:
  - S1 registers the per-position XNOR vectors.
  - S2 registers the CNT_W popcounts.
  - S3 registers the compare + OR into data_out.
- Latency: a patch sampled at edge N gives out_en=1 and valid data_out after edge N+2, i.e. visible in cycle N+3.
- Valid shift chain v1->v2->v3 = out_en; bubbles propagate unchanged.
- When out_en=0, data_out holds its last value.
- Config:
  - On a clk edge with cfg_we=1, weight[cfg_addr] and thr[cfg_addr] update.
  - A patch sampled on that same edge uses the old values; the following patch uses the new ones.
  - cfg_addr >= K: write is ignored.
- Window counter win_cnt, 0..NUM_WIN-1:
  - Increments on each out_en.
  - frame_done = out_en && win_cnt==NUM_WIN-1 (registered alongside out_en).
  - Wraps to 0 after the last window.
- Reset, asynchronous, any time:
  - out_en, frame_done, data_out, v1, v2 and win_cnt go to 0.
  - All weights and thresholds go to 0 (thr=0 means every act=1).
  - Patches in flight are discarded; the first out_en after release comes 3 cycles after the first post-reset in_en.
- The popcount adder tree lives entirely in S2; no arithmetic overflow is possible, since CNT_W covers NW.

Decomposition:
- Shared package/header: parameter defaults, CNT_W, NUM_WIN, and the bit-index helper functions for patch and weight layout.
- One sub-module: bpopcount (NW-bit input, CNT_W-bit combinational popcount), instantiated K*POOL_H*POOL_W times inside the S2 register stage.

Test Plan:
1. rst=1 for 10 cycles, in_en pulsed -> out_en=0, data_out=0, frame_done=0. Release, one patch -> out_en high exactly 3 cycles later.
2. Config and all-ones patch:
   - Config: filter0 all-ones with thr=18; filter1 all-zeros with thr=1; filter2 all-ones with thr=0; filter3 all-ones with thr=19.
   - Stimulus: data_in all-ones -> data_out=4'b0101.
3. Pooling:
   - Filter0 all-ones, thr=18.
   - Patch all-zeros except a 3x3 all-ones block at rows1-3/cols1-3 -> data_out[0]=1.
   - Same patch with one bit of that block cleared -> data_out[0]=0.
4. Framing: 20 back-to-back patches -> 20 consecutive out_en. frame_done only on output #16; win_cnt wraps; output #17 has frame_done=0.
5. Config timing: cfg_we writing filter0 all-zeros, thr=18, on the same edge as an all-ones patch -> that output bit0=1; the next identical patch -> bit0=0.
6. rst asserted mid-stream with 2 patches in flight -> out_en drops immediately and no stale outputs appear after release. The following frame yields frame_done on its 16th output.
